// File: rtl/rom_loader_pkg.sv
// Shared state encoding and width helpers for the ROM loader.
package rom_loader_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int bytes_of(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/rom_loader_pack.sv
// Little-endian byte packer: 0-cycle word_full on the completing byte.
// No backpressure of its own; the parent gates accept with its ready.
module rom_loader_pack
   import rom_loader_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             accept,
   input  logic [7:0]       in_byte,
   input  logic             in_last,
   output logic             word_full,
   output logic [WIDTH-1:0] word
);

   localparam int BYTES = bytes_of(WIDTH);
   localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] word_q;

   assign word_full = accept & ((idx == LAST_IDX) | in_last);
   assign word      = word_q;

   // clear wins over accept so a byte arriving with a restart is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         word_q <= '0;
      end else if (clear) begin
         idx    <= '0;
         word_q <= '0;
      end else if (accept) begin
         word_q[8*int'(idx) +: 8] <= in_byte;
         idx <= word_full ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/rom_loader.sv
// Packs download bytes into WIDTH-bit words and writes them from address 0.
// Word write one cycle after the completing byte; dl_ready drops during the write and once done.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int WIDTHAD = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               dl_start,
   input  logic               dl_valid,
   input  logic [7:0]         dl_data,
   input  logic               dl_last,
   output logic               dl_ready,
   output logic               wr_en,
   output logic [WIDTHAD-1:0] wr_addr,
   output logic [WIDTH-1:0]   wr_data,
   output logic               busy,
   output logic               done,
   output logic               overflow,
   output logic [WIDTHAD:0]   words_written
);

   localparam logic [WIDTHAD:0] WORDS_MAX = {1'b1, {WIDTHAD{1'b0}}};

   logic [1:0]         state;
   logic [WIDTHAD-1:0] addr;
   logic [WIDTHAD:0]   words;
   logic               pend_last;
   logic               ovf_q;
   logic               accept;
   logic               word_full;
   logic               pack_clear;

   assign dl_ready      = (state == ST_FILL);
   assign wr_en         = (state == ST_WRITE);
   assign busy          = (state == ST_FILL) | (state == ST_WRITE);
   assign done          = (state == ST_DONE);
   assign overflow      = ovf_q;
   assign wr_addr       = addr;
   assign words_written = words;

   assign accept     = dl_valid & dl_ready & ~dl_start;
   assign pack_clear = dl_start | (state == ST_WRITE);

   rom_loader_pack #(.WIDTH(WIDTH)) u_pack (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pack_clear),
      .accept    (accept),
      .in_byte   (dl_data),
      .in_last   (dl_last),
      .word_full (word_full),
      .word      (wr_data)
   );

   // A restart overrides every transition; a WRITE in flight still strobes this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr      <= '0;
         words     <= '0;
         pend_last <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (dl_start) begin
         state     <= ST_FILL;
         addr      <= '0;
         words     <= '0;
         pend_last <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         case (state)
            ST_FILL: begin
               if (word_full) begin
                  state     <= ST_WRITE;
                  pend_last <= dl_last;
               end
            end
            ST_WRITE: begin
               addr <= addr + 1'b1;
               if (words != WORDS_MAX)
                  words <= words + 1'b1;
               if (pend_last) begin
                  state <= ST_DONE;
               end else if (&addr) begin
                  state <= ST_DONE;
                  ovf_q <= 1'b1;
               end else begin
                  state <= ST_FILL;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

   localparam int WIDTH   = 32;
   localparam int WIDTHAD = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               dl_start = 1'b0;
   logic               dl_valid = 1'b0;
   logic [7:0]         dl_data = '0;
   logic               dl_last = 1'b0;
   logic               dl_ready;
   logic               wr_en;
   logic [WIDTHAD-1:0] wr_addr;
   logic [WIDTH-1:0]   wr_data;
   logic               busy;
   logic               done;
   logic               overflow;
   logic [WIDTHAD:0]   words_written;

   int tests = 0;
   int fails = 0;

   logic [WIDTHAD+WIDTH-1:0] exp_q[$];
   logic prev_wr = 1'b0;

   rom_loader #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dl_start      (dl_start),
      .dl_valid      (dl_valid),
      .dl_data       (dl_data),
      .dl_last       (dl_last),
      .dl_ready      (dl_ready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe is matched against the scoreboard queue.
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         check("dl_ready_in_write", 64'(dl_ready), 64'd0);
         check("wr_en_single_cycle", 64'(prev_wr), 64'd0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", wr_addr, wr_data);
         end else begin
            logic [WIDTHAD+WIDTH-1:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(e[WIDTHAD+WIDTH-1:WIDTH]));
            check("wr_data", 64'(wr_data), 64'(e[WIDTH-1:0]));
         end
      end
      prev_wr <= rst_n & wr_en;
   end

   task automatic expect_wr(input logic [WIDTHAD-1:0] a, input logic [WIDTH-1:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic start_img();
      @(negedge clk);
      dl_start = 1'b1;
      @(negedge clk);
      dl_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
      int n;
      n = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      dl_valid = 1'b1;
      dl_data  = d;
      dl_last  = l;
      while (!dl_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: dl_ready stayed %0d, needed 1", dl_ready);
      end
      @(posedge clk);
      #1;
      dl_valid = 1'b0;
      dl_last  = 1'b0;
   endtask

   task automatic stray_byte(input logic [7:0] d);
      @(negedge clk);
      dl_valid = 1'b1;
      dl_data  = d;
      @(negedge clk);
      dl_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", 64'(done), 64'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_dl_ready"}, 64'(dl_ready), 64'd0);
      check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_overflow"}, 64'(overflow), 64'd0);
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
      check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
      check({tag, "_words"}, 64'(words_written), 64'd0);
   endtask

   logic [7:0] img_a [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   logic [7:0] img_g [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};

   initial begin
      #1;
      check_idle_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ready", 64'(dl_ready), 64'd0);

      // two full words
      start_img();
      expect_wr(2'd0, 32'h44332211);
      expect_wr(2'd1, 32'h88776655);
      for (int i = 0; i < 8; i++) send_byte(img_a[i], i == 7, 0);
      wait_done();
      check("a_words", 64'(words_written), 64'd2);
      check("a_ovf", 64'(overflow), 64'd0);
      check("a_busy", 64'(busy), 64'd0);

      // partial last word, unfilled lanes zero
      start_img();
      check("b_done_cleared", 64'(done), 64'd0);
      check("b_busy", 64'(busy), 64'd1);
      expect_wr(2'd0, 32'h0000BBAA);
      send_byte(8'hAA, 1'b0, 0);
      send_byte(8'hBB, 1'b1, 0);
      wait_done();
      check("b_words", 64'(words_written), 64'd1);

      // overflow: 16 bytes fill depth 4, then stray bytes are ignored
      start_img();
      expect_wr(2'd0, 32'h04030201);
      expect_wr(2'd1, 32'h08070605);
      expect_wr(2'd2, 32'h0C0B0A09);
      expect_wr(2'd3, 32'h100F0E0D);
      for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0, 0);
      wait_done();
      for (int i = 17; i <= 20; i++) stray_byte(8'(i));
      repeat (3) @(negedge clk);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_done", 64'(done), 64'd1);
      check("ovf_words", 64'(words_written), 64'd4);

      // abort after 6 bytes; the restart pulse carries a byte that must be dropped
      start_img();
      expect_wr(2'd0, 32'h34333231);
      for (int i = 1; i <= 6; i++) send_byte(8'h30 + 8'(i), 1'b0, 0);
      @(negedge clk);
      dl_start = 1'b1;
      dl_valid = 1'b1;
      dl_data  = 8'hEE;
      @(negedge clk);
      dl_start = 1'b0;
      dl_valid = 1'b0;
      check("abort_words", 64'(words_written), 64'd0);
      check("abort_addr", 64'(wr_addr), 64'd0);
      check("abort_ovf", 64'(overflow), 64'd0);
      expect_wr(2'd0, 32'h00C3C2C1);
      send_byte(8'hC1, 1'b0, 0);
      send_byte(8'hC2, 1'b0, 0);
      send_byte(8'hC3, 1'b1, 0);
      wait_done();
      check("abort_new_words", 64'(words_written), 64'd1);

      // random valid gaps
      start_img();
      expect_wr(2'd0, 32'hD4C3B2A1);
      expect_wr(2'd1, 32'h1807F6E5);
      for (int i = 0; i < 8; i++) send_byte(img_g[i], i == 7, $urandom_range(0, 3));
      wait_done();
      check("gap_words", 64'(words_written), 64'd2);

      // async reset mid-FILL drops the partial word
      start_img();
      send_byte(8'h55, 1'b0, 0);
      send_byte(8'h66, 1'b0, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      start_img();
      expect_wr(2'd0, 32'h04030201);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 4, 0);
      wait_done();
      check("rst_reload_words", 64'(words_written), 64'd1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, expected to finish");
      $fatal(1);
   end

endmodule
